// File: rtl/vga_sprite_compositor_if.sv
// ---------------------------------------------------------------------------
// vga_sprite_compositor_if
// Pixel-rate bundle between the VGA timing generator / game logic and the
// sprite compositor.
//   master : timing/game side. Drives scan position, sprite positions and
//            colours, and per-pixel/frame flags. Receives colour and mode.
//   slave  : compositor side. Mirror of master.
// Signals:
//   h_cnt[10:0], v_cnt[9:0]        current scan position
//   active                         visible-area flag
//   frame_start                    one-cycle pulse per frame
//   player_x/y[9:0], player_dir    Pac-Man top-left corner and facing
//   move_en                        Pac-Man moving (mouth animates)
//   ghost_x_flat/ghost_y_flat      ghost i top-left at [i*10 +: 10]
//   ghost_rgb_flat                 ghost i colour {r,g,b} at [i*12 +: 12]
//   dot_pixel                      current pixel is a dot
//   power_pellet                   one-cycle pulse, (re)starts frightened
//   vga_r/g/b[3:0]                 registered colour out
//   fright_active                  frightened mode running
// ---------------------------------------------------------------------------
interface vga_sprite_compositor_if #(
  parameter int NUM_GHOSTS = 3
);
  logic [10:0]              h_cnt;
  logic [9:0]               v_cnt;
  logic                     active;
  logic                     frame_start;
  logic [9:0]               player_x;
  logic [9:0]               player_y;
  logic [1:0]               player_dir;
  logic                     move_en;
  logic [NUM_GHOSTS*10-1:0] ghost_x_flat;
  logic [NUM_GHOSTS*10-1:0] ghost_y_flat;
  logic [NUM_GHOSTS*12-1:0] ghost_rgb_flat;
  logic                     dot_pixel;
  logic                     power_pellet;
  logic [3:0]               vga_r;
  logic [3:0]               vga_g;
  logic [3:0]               vga_b;
  logic                     fright_active;

  modport master (
    output h_cnt, v_cnt, active, frame_start,
    output player_x, player_y, player_dir, move_en,
    output ghost_x_flat, ghost_y_flat, ghost_rgb_flat,
    output dot_pixel, power_pellet,
    input  vga_r, vga_g, vga_b, fright_active
  );

  modport slave (
    input  h_cnt, v_cnt, active, frame_start,
    input  player_x, player_y, player_dir, move_en,
    input  ghost_x_flat, ghost_y_flat, ghost_rgb_flat,
    input  dot_pixel, power_pellet,
    output vga_r, vga_g, vga_b, fright_active
  );
endinterface

// File: rtl/vga_sprite_compositor.sv
// ---------------------------------------------------------------------------
// vga_sprite_compositor
// Two-stage registered sprite compositor for the Pac-Man VGA path. Draws
// Pac-Man (round body with an animated, direction-aware mouth), NUM_GHOSTS
// rectangular ghosts and the dot layer. Inputs sampled at edge n appear on
// vga_* after edge n+2; sync signals must be delayed 2 cycles externally.
//
// Ports:
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   bus    vga_sprite_compositor_if.slave (scan position, sprite state,
//          dot/pellet flags in; vga_r/g/b and fright_active out)
//
// Build option:
//   VGA_FRIGHTENED_MODE_EN  when defined, builds the frame-timed frightened
//                           counter, blue/blink ghost colouring and
//                           fright_active. Otherwise power_pellet is ignored
//                           and fright_active is tied low.
// ---------------------------------------------------------------------------
module vga_sprite_compositor #(
  parameter int NUM_GHOSTS    = 3,
  parameter int SIZE          = 16,
  parameter int ANIM_FRAMES   = 8,
  parameter int FRIGHT_FRAMES = 360,
  parameter int BLINK_START   = 120
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vga_sprite_compositor_if.slave  bus
);

  localparam int R     = SIZE / 2;
  localparam int DIV_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(ANIM_FRAMES - 1);
  localparam logic signed [24:0] R_SQ     = 25'(R * R);

  localparam logic [11:0] PAC_RGB = 12'hFF0;
  localparam logic [11:0] DOT_RGB = 12'hFFF;

  typedef enum logic [1:0] {
    PH_CLOSED     = 2'd0,
    PH_HALF_OPEN  = 2'd1,
    PH_OPEN       = 2'd2,
    PH_HALF_CLOSE = 2'd3
  } phase_t;

  // Inside the circle dx^2 + dy^2 <= R^2; 25-bit signed holds the full
  // 12-bit offset range squared and summed.
  function automatic logic in_body(input logic signed [11:0] dx,
                                   input logic signed [11:0] dy);
    logic signed [24:0] ex;
    logic signed [24:0] ey;
    logic signed [24:0] d2;
    ex = 25'(dx);
    ey = 25'(dy);
    d2 = ex * ex + ey * ey;
    return d2 <= R_SQ;
  endfunction

  // Mouth wedge: 'along' points out of the mouth, 'perp' is the distance
  // off the mouth axis. HALF is a narrower wedge (slope 1/2) than OPEN.
  function automatic logic mouth_cut(input phase_t            ph,
                                     input logic [1:0]        dir,
                                     input logic signed [11:0] dx,
                                     input logic signed [11:0] dy);
    logic signed [13:0] x;
    logic signed [13:0] y;
    logic signed [13:0] along;
    logic signed [13:0] perp;
    x = 14'(dx);
    y = 14'(dy);
    case (dir)
      2'd0:    begin along = x;  perp = y; end
      2'd1:    begin along = -x; perp = y; end
      2'd2:    begin along = -y; perp = x; end
      default: begin along = y;  perp = x; end
    endcase
    if (perp < 0) perp = -perp;
    case (ph)
      PH_OPEN:                    return (along > 0) && (perp <= along);
      PH_HALF_OPEN, PH_HALF_CLOSE: return (along > 0) && ((perp <<< 1) <= along);
      default:                    return 1'b0;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Mouth animation: phase FSM plus frame divider, both frozen while the
  // player is not moving.
  // -------------------------------------------------------------------------
  phase_t           phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_CLOSED;
      div_q   <= '0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    if (bus.frame_start && bus.move_en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        case (phase_q)
          PH_CLOSED:     phase_d = PH_HALF_OPEN;
          PH_HALF_OPEN:  phase_d = PH_OPEN;
          PH_OPEN:       phase_d = PH_HALF_CLOSE;
          default:       phase_d = PH_CLOSED;
        endcase
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Frightened mode: ghost colour override shared by all ghosts.
  // -------------------------------------------------------------------------
  logic        fright_sel;
  logic [11:0] fright_col;

`ifdef VGA_FRIGHTENED_MODE_EN
  logic [9:0] fc_q, fc_d;
  logic       fright_q;

  // A pellet reloads the count and wins over a same-cycle frame_start.
  always_comb begin
    fc_d = fc_q;
    if (bus.power_pellet) begin
      fc_d = 10'(FRIGHT_FRAMES);
    end else if (bus.frame_start && (fc_q != '0)) begin
      fc_d = fc_q - 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q     <= '0;
      fright_q <= 1'b0;
    end else begin
      fc_q     <= fc_d;
      fright_q <= (fc_d != '0);
    end
  end

  assign fright_sel        = (fc_q != '0);
  assign fright_col        = ((fc_q <= 10'(BLINK_START)) && fc_q[3]) ? 12'hFFF : 12'h00F;
  assign bus.fright_active = fright_q;
`else
  logic unused_power_pellet;
  assign unused_power_pellet = bus.power_pellet;
  assign fright_sel          = 1'b0;
  assign fright_col          = 12'h000;
  assign bus.fright_active   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Stage 0 -> 1: hit tests and per-ghost colour selection.
  // -------------------------------------------------------------------------
  logic [11:0]        pac_cx;
  logic [11:0]        pac_cy;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic               pac_hit_d;
  logic [NUM_GHOSTS-1:0] ghost_hit_d;
  logic [11:0]           ghost_col_d [NUM_GHOSTS];

  assign pac_cx    = {2'b00, bus.player_x} + 12'(R);
  assign pac_cy    = {2'b00, bus.player_y} + 12'(R);
  assign dx        = $signed({1'b0, bus.h_cnt}) - $signed(pac_cx);
  assign dy        = $signed({2'b00, bus.v_cnt}) - $signed(pac_cy);
  assign pac_hit_d = in_body(dx, dy) && !mouth_cut(phase_q, bus.player_dir, dx, dy);

  // Bounds are compared at 12 bits so a ghost straddling the right or
  // bottom edge of the 10-bit coordinate range does not wrap to column 0.
  for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
    logic [11:0] gx;
    logic [11:0] gy;
    logic [11:0] hx;
    logic [11:0] vy;
    assign gx = {2'b00, bus.ghost_x_flat[gi*10 +: 10]};
    assign gy = {2'b00, bus.ghost_y_flat[gi*10 +: 10]};
    assign hx = {1'b0, bus.h_cnt};
    assign vy = {2'b00, bus.v_cnt};
    assign ghost_hit_d[gi] = (hx >= gx) && (hx < gx + 12'(SIZE)) &&
                             (vy >= gy) && (vy < gy + 12'(SIZE));
    assign ghost_col_d[gi] = fright_sel ? fright_col : bus.ghost_rgb_flat[gi*12 +: 12];
  end

  logic                  vld_p1;
  logic                  pac_hit_p1;
  logic                  dot_p1;
  logic [NUM_GHOSTS-1:0] ghost_hit_p1;
  logic [11:0]           ghost_col_p1 [NUM_GHOSTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      pac_hit_p1   <= 1'b0;
      dot_p1       <= 1'b0;
      ghost_hit_p1 <= '0;
    end else begin
      vld_p1       <= bus.active;
      pac_hit_p1   <= pac_hit_d;
      dot_p1       <= bus.dot_pixel;
      ghost_hit_p1 <= ghost_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    ghost_col_p1 <= ghost_col_d;
  end

  // -------------------------------------------------------------------------
  // Stage 1 -> 2: priority mux Pac-Man > ghost 0..N-1 > dot > black.
  // -------------------------------------------------------------------------
  logic [11:0] rgb_d;
  logic [11:0] rgb_p2;

  always_comb begin
    rgb_d = 12'h000;
    if (dot_p1) rgb_d = DOT_RGB;
    // Walk from lowest priority upward so ghost 0 ends up on top.
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      if (ghost_hit_p1[i]) rgb_d = ghost_col_p1[i];
    end
    if (pac_hit_p1) rgb_d = PAC_RGB;
    if (!vld_p1)    rgb_d = 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2 <= 12'h000;
    end else begin
      rgb_p2 <= rgb_d;
    end
  end

  assign bus.vga_r = rgb_p2[11:8];
  assign bus.vga_g = rgb_p2[7:4];
  assign bus.vga_b = rgb_p2[3:0];

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// ---------------------------------------------------------------------------
// tb_vga_sprite_compositor
// Directed bench for vga_sprite_compositor with default parameters
// (NUM_GHOSTS=3, SIZE=16, ANIM_FRAMES=8, FRIGHT_FRAMES=360, BLINK_START=120).
// Frightened-mode checks follow VGA_FRIGHTENED_MODE_EN.
// ---------------------------------------------------------------------------
module tb_vga_sprite_compositor;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  vga_sprite_compositor_if #(.NUM_GHOSTS(3)) bus ();

  vga_sprite_compositor #(
    .NUM_GHOSTS   (3),
    .SIZE         (16),
    .ANIM_FRAMES  (8),
    .FRIGHT_FRAMES(360),
    .BLINK_START  (120)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {20'h0, bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      bus.frame_start = 1'b1;
      tick(1);
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic pellet();
    bus.power_pellet = 1'b1;
    tick(1);
    bus.power_pellet = 1'b0;
  endtask

  task automatic set_ghost(input int i, input int x, input int y, input logic [11:0] col);
    bus.ghost_x_flat[i*10 +: 10]   = 10'(x);
    bus.ghost_y_flat[i*10 +: 10]   = 10'(y);
    bus.ghost_rgb_flat[i*12 +: 12] = col;
  endtask

  // Set the scan position, wait out the 2-cycle pipeline, compare colour.
  task automatic probe(input string tag, input int x, input int y, input logic [11:0] exp);
    bus.h_cnt = 11'(x);
    bus.v_cnt = 10'(y);
    tick(2);
    check_eq(tag, rgb(), {20'h0, exp});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    rst_n              = 1'b0;
    bus.h_cnt          = 11'd108;
    bus.v_cnt          = 10'd108;
    bus.active         = 1'b1;
    bus.frame_start    = 1'b0;
    bus.player_x       = 10'd100;
    bus.player_y       = 10'd100;
    bus.player_dir     = 2'd0;
    bus.move_en        = 1'b1;
    bus.ghost_x_flat   = '0;
    bus.ghost_y_flat   = '0;
    bus.ghost_rgb_flat = '0;
    bus.dot_pixel      = 1'b0;
    bus.power_pellet   = 1'b0;
    set_ghost(0, 900, 700, 12'hF00);
    set_ghost(1, 900, 700, 12'h5FA);
    set_ghost(2, 900, 700, 12'h0F0);

    // Reset with Pac-Man centred on the pixel.
    tick(3);
    check_eq("reset_rgb", rgb(), 32'h000);
    check_eq("reset_fright", {31'h0, bus.fright_active}, 32'h0);
    rst_n = 1'b1;
    tick(1);
    check_eq("release_lat1", rgb(), 32'h000);
    tick(1);
    check_eq("release_lat2", rgb(), 32'hFF0);

    // Mouth animation. P1=(115,108) hidden by HALF and OPEN, P2=(113,104)
    // hidden by OPEN only.
    probe("closed_p1", 115, 108, 12'hFF0);
    pulse(7);
    probe("pulse7_closed", 115, 108, 12'hFF0);
    pulse(1);
    probe("pulse8_half_p1", 115, 108, 12'h000);
    probe("pulse8_half_p2", 113, 104, 12'hFF0);
    pulse(8);
    probe("pulse16_open_p2", 113, 104, 12'h000);
    probe("open_p1", 115, 108, 12'h000);
    probe("open_back", 101, 108, 12'hFF0);
    probe("open_top_edge", 108, 100, 12'hFF0);
    bus.player_dir = 2'd1;
    probe("dir_left", 101, 108, 12'h000);
    probe("dir_left_back", 115, 108, 12'hFF0);
    bus.player_dir = 2'd2;
    probe("dir_up", 108, 101, 12'h000);
    bus.player_dir = 2'd3;
    probe("dir_down", 108, 115, 12'h000);
    bus.player_dir = 2'd0;
    pulse(8);
    probe("pulse24_half_p2", 113, 104, 12'hFF0);
    probe("pulse24_half_p1", 115, 108, 12'h000);
    pulse(8);
    probe("pulse32_closed", 115, 108, 12'hFF0);

    // Hold: step to HALF at pulse 8, drop move_en after pulse 10.
    pulse(10);
    bus.move_en = 1'b0;
    pulse(10);
    probe("hold_half_p1", 115, 108, 12'h000);
    probe("hold_half_p2", 113, 104, 12'hFF0);
    bus.move_en = 1'b1;
    pulse(5);
    probe("resume_div7", 113, 104, 12'hFF0);
    pulse(1);
    probe("resume_open", 113, 104, 12'h000);

    // Ghost priority, edges and dot layer; Pac-Man parked away.
    bus.player_x = 10'd500;
    bus.player_y = 10'd400;
    set_ghost(0, 195, 45, 12'hF00);
    set_ghost(1, 190, 40, 12'h5FA);
    probe("ghost0_over_1", 200, 50, 12'hF00);
    set_ghost(0, 900, 700, 12'hF00);
    probe("ghost1_alone", 200, 50, 12'h5FA);
    probe("ghost_edge_in", 205, 50, 12'h5FA);
    probe("ghost_edge_out", 206, 50, 12'h000);
    bus.dot_pixel = 1'b1;
    probe("dot_only", 206, 50, 12'hFFF);
    probe("dot_under_ghost", 200, 50, 12'h5FA);
    bus.dot_pixel = 1'b0;
    bus.player_x = 10'd195;
    bus.player_y = 10'd45;
    probe("pac_over_ghost", 200, 50, 12'hFF0);
    bus.player_x = 10'd500;
    bus.player_y = 10'd400;
    set_ghost(2, 1020, 1015, 12'h0F0);
    probe("ghost_no_wrap", 1030, 1020, 12'h0F0);

    // Blanking follows the same 2-cycle latency.
    bus.active = 1'b0;
    tick(1);
    check_eq("blank_lat1", rgb(), 32'h0F0);
    tick(1);
    check_eq("blank_lat2", rgb(), 32'h000);
    bus.active = 1'b1;
    tick(2);

    // Asynchronous reset mid-frame blanks immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", rgb(), 32'h000);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_eq("post_reset_lat1", rgb(), 32'h000);
    tick(1);
    check_eq("post_reset", rgb(), 32'h0F0);

`ifdef VGA_FRIGHTENED_MODE_EN
    bus.h_cnt = 11'd200;
    bus.v_cnt = 10'd50;
    pellet();
    check_eq("fright_on", {31'h0, bus.fright_active}, 32'h1);
    pulse(160);
    probe("fc200_blue", 200, 50, 12'h00F);
    pulse(80);
    probe("fc120_white", 200, 50, 12'hFFF);
    pulse(1);
    probe("fc119_blue", 200, 50, 12'h00F);
    pulse(118);
    check_eq("fright_pulse359", {31'h0, bus.fright_active}, 32'h1);
    pulse(1);
    check_eq("fright_pulse360", {31'h0, bus.fright_active}, 32'h0);
    probe("fright_end_colour", 200, 50, 12'h5FA);

    pellet();
    pulse(355);
    pellet();
    pulse(6);
    check_eq("reload_active", {31'h0, bus.fright_active}, 32'h1);
    probe("reload_blue", 200, 50, 12'h00F);

    bus.power_pellet = 1'b1;
    bus.frame_start  = 1'b1;
    tick(1);
    bus.power_pellet = 1'b0;
    bus.frame_start  = 1'b0;
    pulse(359);
    check_eq("same_cycle_359", {31'h0, bus.fright_active}, 32'h1);
    pulse(1);
    check_eq("same_cycle_360", {31'h0, bus.fright_active}, 32'h0);
`else
    pellet();
    check_eq("no_fright_active", {31'h0, bus.fright_active}, 32'h0);
    pulse(3);
    probe("no_fright_colour", 200, 50, 12'h5FA);
    check_eq("no_fright_still", {31'h0, bus.fright_active}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
